mem_access_ctrl: RTL

- Memory-stage controller sitting directly upstream of the data memory.
- Takes one load/store request per instruction from the EX/MEM pipeline register and drives the data-memory port (wrEnable, rdEnable, numberOfByte, address, in).
- An unaligned 16-bit access becomes two byte accesses. The pipeline is stalled until the access finishes.
- Returns the load result to writeback with a one-cycle respValid pulse.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_access_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-stage controller: request size codes,
// data-memory numberOfByte codes and the controller state encoding.
// Optional feature macro used by the controller: MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
package mem_pkg;

    // Request size codes (reqSize). 2'b11 is folded onto SZ_BYTE_Z.
    localparam logic [1:0] SZ_WORD   = 2'b00;
    localparam logic [1:0] SZ_BYTE_Z = 2'b01;
    localparam logic [1:0] SZ_BYTE_S = 2'b10;

    // Data-memory numberOfByte codes.
    localparam logic [1:0] WR_TWO    = 2'b10;
    localparam logic [1:0] WR_ONE    = 2'b00;
    localparam logic [1:0] RD_WORD   = 2'b00;
    localparam logic [1:0] RD_BYTE_Z = 2'b01;
    localparam logic [1:0] RD_BYTE_S = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACC_LO  = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_ACC_HI  = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Fold the reserved size code onto zero-extended byte.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_BYTE_Z : size;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage controller between the EX/MEM register and the data memory.
// Accepts one load/store per instruction, drives the data-memory port, splits
// an unaligned 16-bit access into two byte accesses, stalls the pipeline until
// the access is finished and returns the load result with a 1-cycle respValid.
//
// Optional feature: MISALIGN_TRAP_EN. When defined, an unaligned word access
// is not split; it completes with no memory access and pulses misalignTrap.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   reqValid/reqWrite/reqSize/reqAddr/reqData   request from EX/MEM
//   stall                 freeze upstream pipeline
//   respValid, loadData   completion pulse and load result
//   memWrEnable, memRdEnable, memNumberOfByte, memAddress, memIn  to memory
//   memOut                read data from memory (valid the cycle after a read)
//   dbgState              current FSM state (mem_pkg::state_t encoding)
//   misalignTrap          (MISALIGN_TRAP_EN only) unaligned word trap pulse
//
// Handshake: a request is taken in IDLE on any rising edge where reqValid=1;
// stall stays high from that cycle until the DONE cycle, in which
// respValid=1 and stall=0 so the pipeline advances exactly once.
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqValid,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [15:0]       reqData,
    output logic              stall,
    output logic              respValid,
    output logic [15:0]       loadData,
    output logic              memWrEnable,
    output logic              memRdEnable,
    output logic [1:0]        memNumberOfByte,
    output logic [ADDR_W-1:0] memAddress,
    output logic [15:0]       memIn,
    input  logic [15:0]       memOut,
    output logic [2:0]        dbgState
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalignTrap
`endif
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data_hi;
    logic              r_write;
    logic              r_split;
    logic              r_resp_valid;
    logic [15:0]       r_load_data;
    logic              r_mem_wr;
    logic              r_mem_rd;
    logic [1:0]        r_mem_nob;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_in;
    logic              r_trap;

    logic [1:0]        w_size;
    logic              w_split;
    logic [ADDR_W-1:0] w_addr_hi;

    assign w_size    = norm_size(reqSize);
    // Only word accesses at an odd address are split; bytes never are.
    assign w_split   = (w_size == SZ_WORD) && reqAddr[0];
    assign w_addr_hi = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // The memory port is fully registered: every transition below loads the
    // port values for the state being entered, so req* never reaches mem*
    // combinationally and enables drop to 0 in every non-access state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_data_hi    <= '0;
            r_write      <= 1'b0;
            r_split      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_load_data  <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_nob    <= '0;
            r_mem_addr   <= '0;
            r_mem_in     <= '0;
            r_trap       <= 1'b0;
        end else begin
            r_mem_wr     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_nob    <= '0;
            r_mem_addr   <= '0;
            r_resp_valid <= 1'b0;
            r_trap       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (reqValid) begin
                        r_addr    <= reqAddr;
                        r_data_hi <= reqData[15:8];
                        r_write   <= reqWrite;
                        r_split   <= w_split;
`ifdef MISALIGN_TRAP_EN
                        if (w_split) begin
                            r_state      <= ST_DONE;
                            r_resp_valid <= 1'b1;
                            r_trap       <= 1'b1;
                            r_load_data  <= '0;
                        end else begin
`else
                        begin
`endif
                            r_state    <= ST_ACC_LO;
                            r_mem_addr <= reqAddr;
                            r_mem_wr   <= reqWrite;
                            r_mem_rd   <= ~reqWrite;
                            if (reqWrite) begin
                                r_mem_nob <= (w_size == SZ_WORD && !w_split) ? WR_TWO : WR_ONE;
                                r_mem_in  <= w_split ? {8'h00, reqData[7:0]} : reqData;
                            end else begin
                                // Size codes for word/byte reads match RD_* codes.
                                r_mem_nob <= w_split ? RD_BYTE_Z : w_size;
                            end
                        end
                    end
                end

                ST_ACC_LO: begin
                    if (r_write && r_split) begin
                        r_state    <= ST_ACC_HI;
                        r_mem_wr   <= 1'b1;
                        r_mem_nob  <= WR_ONE;
                        r_mem_addr <= w_addr_hi;
                        r_mem_in   <= {8'h00, r_data_hi};
                    end else if (r_write) begin
                        r_state      <= ST_DONE;
                        r_resp_valid <= 1'b1;
                        r_load_data  <= '0;
                    end else begin
                        r_state <= ST_WAIT_LO;
                    end
                end

                ST_WAIT_LO: begin
                    if (r_split) begin
                        r_load_data <= {8'h00, memOut[7:0]};
                        r_state     <= ST_ACC_HI;
                        r_mem_rd    <= 1'b1;
                        r_mem_nob   <= RD_BYTE_Z;
                        r_mem_addr  <= w_addr_hi;
                    end else begin
                        r_load_data  <= memOut;
                        r_state      <= ST_DONE;
                        r_resp_valid <= 1'b1;
                    end
                end

                ST_ACC_HI: begin
                    if (r_write) begin
                        r_state      <= ST_DONE;
                        r_resp_valid <= 1'b1;
                        r_load_data  <= '0;
                    end else begin
                        r_state <= ST_WAIT_HI;
                    end
                end

                ST_WAIT_HI: begin
                    r_load_data[15:8] <= memOut[7:0];
                    r_state           <= ST_DONE;
                    r_resp_valid      <= 1'b1;
                end

                ST_DONE: begin
                    // reqValid is ignored here; the next request is seen in IDLE.
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall           = (r_state == ST_IDLE) ? reqValid : (r_state != ST_DONE);
    assign respValid       = r_resp_valid;
    assign loadData        = r_load_data;
    assign memWrEnable     = r_mem_wr;
    assign memRdEnable     = r_mem_rd;
    assign memNumberOfByte = r_mem_nob;
    assign memAddress      = r_mem_addr;
    assign memIn           = r_mem_in;
    assign dbgState        = r_state;
`ifdef MISALIGN_TRAP_EN
    assign misalignTrap    = r_trap;
`else
    logic w_trap_unused;
    assign w_trap_unused = r_trap;
`endif

endmodule
